// File: rtl/adc_fifo_pkg.sv
// Shared constants, channel-width helper and storage word layout for the ADC sample FIFO.
package adc_fifo_pkg;

  localparam int ADC_DATA_WIDTH = 16;
  localparam int ADC_NUM_CH     = 8;

  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int ADC_CH_W = ch_w(ADC_NUM_CH);

  typedef struct packed {
    logic [ADC_CH_W-1:0]       ch;
    logic [ADC_DATA_WIDTH-1:0] data;
  } adc_entry_t;

endpackage

// File: rtl/adc_fifo_ram.sv
// Simple dual-port synchronous RAM with registered read and no reset, so it maps onto block RAM.
module adc_fifo_ram
  import adc_fifo_pkg::*;
#(
  parameter int DEPTH = 16384,
  parameter int WIDTH = ADC_CH_W + ADC_DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read sees the pre-write contents when addresses collide.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/adc_sample_fifo.sv
// Channel-tagged sample FIFO between ADC capture and the SPI link: exact full via a wide count,
// programmable thresholds, sticky overflow/underflow, synchronous flush, registered read with valid strobe.
module adc_sample_fifo
  import adc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = ADC_DATA_WIDTH,
  parameter int DEPTH      = 16384,
  parameter int NUM_CH     = ADC_NUM_CH,
  parameter int AFULL_LVL  = DEPTH - 8,
  parameter int AEMPTY_LVL = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         wr_en,
  input  logic [ch_w(NUM_CH)-1:0]      wr_ch,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         rd_en,
  output logic                         rd_valid,
  output logic [ch_w(NUM_CH)-1:0]      rd_ch,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int CH_W = ch_w(NUM_CH);
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;

  // Same layout as adc_entry_t, but sized by this instance's parameters.
  typedef struct packed {
    logic [CH_W-1:0]       ch;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_acc;
  logic          rd_acc;
  logic          rd_seen;
  entry_t        wr_entry;
  entry_t        rd_entry;

  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AFULL_LVL));
  assign almost_empty = (count <= CW'(AEMPTY_LVL));

  assign wr_acc = wr_en & ~full  & ~flush;
  assign rd_acc = rd_en & ~empty & ~flush;

  assign wr_entry.ch   = wr_ch;
  assign wr_entry.data = wr_data;

  adc_fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (CH_W + DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (wr_entry),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr),
    .rd_data (rd_entry)
  );

  // The RAM output register has no reset; mask it until a read has completed since reset.
  assign rd_ch   = rd_seen ? rd_entry.ch   : '0;
  assign rd_data = rd_seen ? rd_entry.data : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      rd_valid  <= 1'b0;
      rd_seen   <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) rd_seen <= 1'b1;
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      if (wr_acc && !rd_acc)      count <= count + CW'(1);
      else if (rd_acc && !wr_acc) count <= count - CW'(1);
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adc_sample_fifo.sv
// Directed self-checking bench for adc_sample_fifo with DEPTH=8, AFULL_LVL=6, AEMPTY_LVL=1.
module tb_adc_sample_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int NCH   = 8;
  localparam int AFL   = 6;
  localparam int AEL   = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        wr_en;
  logic [2:0]  wr_ch;
  logic [15:0] wr_data;
  logic        rd_en;
  logic        rd_valid;
  logic [2:0]  rd_ch;
  logic [15:0] rd_data;
  logic [3:0]  count;
  logic        full, empty, almost_full, almost_empty, overflow, underflow;

  int errors = 0;
  int checks = 0;

  adc_sample_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .NUM_CH     (NCH),
    .AFULL_LVL  (AFL),
    .AEMPTY_LVL (AEL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .wr_en        (wr_en),
    .wr_ch        (wr_ch),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_valid     (rd_valid),
    .rd_ch        (rd_ch),
    .rd_data      (rd_data),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
  endtask

  task automatic push(input logic [2:0] ch, input logic [15:0] d);
    wr_en = 1'b1; rd_en = 1'b0; wr_ch = ch; wr_data = d;
    tick();
    idle();
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_ch = '0; wr_data = '0;
    #3;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_aempty", almost_empty, 1);
    check("rst_afull", almost_full, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_ch", rd_ch, 0);
    check("rst_ovf", overflow, 0);
    check("rst_udf", underflow, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Basic write 8 / read 8 in order.
    for (int i = 0; i < 8; i++) push(3'(i), 16'(16'h1000 + i));
    check("fill_count", count, 8);
    check("fill_full", full, 1);
    rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("seq_valid", rd_valid, 1);
      check("seq_ch", rd_ch, i);
      check("seq_data", rd_data, 32'h1000 + i);
    end
    idle();
    tick();
    check("seq_valid_low", rd_valid, 0);
    check("seq_data_hold", rd_data, 32'h1007);
    check("seq_empty", empty, 1);
    check("seq_ovf", overflow, 0);
    check("seq_udf", underflow, 0);

    // Overflow while full, then simultaneous read+write at full.
    for (int i = 0; i < 8; i++) push(3'(i), 16'(16'h2000 + i));
    push(3'd7, 16'hBEEF);
    check("ovf_full", full, 1);
    check("ovf_count", count, 8);
    check("ovf_flag", overflow, 1);
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 16'hBEEF; wr_ch = 3'd7;
    tick();
    idle();
    check("full_rw_count", count, 7);
    check("full_rw_data", rd_data, 32'h2000);
    check("full_rw_ch", rd_ch, 0);
    check("full_rw_ovf", overflow, 1);
    for (int i = 1; i < 8; i++) begin
      rd_en = 1'b1;
      tick();
      check("ovf_drain_data", rd_data, 32'h2000 + i);
    end
    idle();
    tick();
    check("ovf_drain_empty", empty, 1);
    check("ovf_sticky", overflow, 1);
    flush = 1'b1;
    tick();
    idle();
    check("flush1_ovf", overflow, 0);

    // Steady state at count 4 with simultaneous traffic across pointer wraps.
    for (int i = 0; i < 4; i++) push(3'(i), 16'(16'h3000 + i));
    for (int j = 0; j < 20; j++) begin
      wr_en = 1'b1; rd_en = 1'b1; wr_ch = 3'((j + 4) % 8); wr_data = 16'(16'h3000 + j + 4);
      tick();
      check("rw_valid", rd_valid, 1);
      check("rw_count", count, 4);
      check("rw_data", rd_data, 32'h3000 + j);
      check("rw_ch", rd_ch, j % 8);
    end
    idle();
    for (int j = 20; j < 24; j++) begin
      rd_en = 1'b1;
      tick();
      check("rw_tail_data", rd_data, 32'h3000 + j);
    end
    idle();
    tick();
    check("rw_empty", empty, 1);
    check("rw_udf", underflow, 0);

    // Simultaneous read+write while empty.
    wr_en = 1'b1; rd_en = 1'b1; wr_ch = 3'd5; wr_data = 16'h00AA;
    tick();
    idle();
    check("emp_rw_udf", underflow, 1);
    check("emp_rw_count", count, 1);
    check("emp_rw_valid", rd_valid, 0);
    rd_en = 1'b1;
    tick();
    idle();
    check("emp_rd_valid", rd_valid, 1);
    check("emp_rd_data", rd_data, 32'h00AA);
    check("emp_rd_ch", rd_ch, 5);
    tick();
    check("emp_rd_valid_low", rd_valid, 0);
    check("emp_count0", count, 0);

    // Threshold sweep 0 -> 8 -> 0.
    check("sw_ae_0", almost_empty, 1);
    check("sw_af_0", almost_full, 0);
    for (int c = 1; c <= 8; c++) begin
      push(3'(c % 8), 16'(16'h4000 + c));
      check("sw_up_count", count, c);
      check("sw_up_ae", almost_empty, (c <= AEL) ? 1 : 0);
      check("sw_up_af", almost_full, (c >= AFL) ? 1 : 0);
    end
    for (int c = 7; c >= 0; c--) begin
      rd_en = 1'b1;
      tick();
      idle();
      check("sw_dn_count", count, c);
      check("sw_dn_ae", almost_empty, (c <= AEL) ? 1 : 0);
      check("sw_dn_af", almost_full, (c >= AFL) ? 1 : 0);
    end

    // Flush at count 5 with overflow set; requests in the flush cycle are ignored.
    for (int i = 0; i < 8; i++) push(3'(i), 16'(16'h5000 + i));
    push(3'd0, 16'hDEAD);
    for (int i = 0; i < 3; i++) begin
      rd_en = 1'b1;
      tick();
    end
    idle();
    check("pre_flush_count", count, 5);
    check("pre_flush_ovf", overflow, 1);
    flush = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 16'h1234;
    tick();
    idle();
    check("flush_count", count, 0);
    check("flush_empty", empty, 1);
    check("flush_ovf", overflow, 0);
    check("flush_udf", underflow, 0);
    check("flush_valid", rd_valid, 0);

    // Asynchronous reset mid-cycle with count 3 and a read just returned.
    for (int i = 0; i < 4; i++) push(3'(i), 16'(16'h6000 + i));
    rd_en = 1'b1;
    tick();
    idle();
    check("prerst_count", count, 3);
    check("prerst_valid", rd_valid, 1);
    check("prerst_data", rd_data, 32'h6000);
    #2;
    rst = 1'b0;
    #1;
    check("arst_count", count, 0);
    check("arst_empty", empty, 1);
    check("arst_valid", rd_valid, 0);
    check("arst_data", rd_data, 0);
    check("arst_ch", rd_ch, 0);
    check("arst_ovf", overflow, 0);
    check("arst_udf", underflow, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("post_rst_empty", empty, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_sample_fifo.md
Name: adc_sample_fifo

Overview:
- Parametrised, channel-tagged sample FIFO between the ADS8528 capture logic and the SPI link to the Raspberry Pi.
- Stores each conversion result with its channel index.
- Adds programmable almost-full/almost-empty levels, sticky overflow/underflow flags, a synchronous flush and a registered read with a valid strobe.
- Count is one bit wider than the address, so full is exact.

Parameters:
- DATA_WIDTH, 16, sample width in bits.
- DEPTH, 16384, number of entries; must be a power of two and at least 4.
- NUM_CH, 8, number of ADC channels; CH_W = max(1, $clog2(NUM_CH)).
- AFULL_LVL, DEPTH-8, almost_full asserts when count >= AFULL_LVL.
- AEMPTY_LVL, 8, almost_empty asserts when count <= AEMPTY_LVL.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of pointers, count and flags.
- wr_en  in  1  write request.
- wr_ch  in  CH_W  channel index of wr_data.
- wr_data  in  DATA_WIDTH  sample to store.
- rd_en  in  1  read request.
- rd_valid  out  1  one-cycle strobe: rd_data/rd_ch hold a newly read entry.
- rd_ch  out  CH_W  channel of the entry read.
- rd_data  out  DATA_WIDTH  sample read.
- count  out  $clog2(DEPTH)+1  entries currently stored, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_LVL.
- almost_empty  out  1  count <= AEMPTY_LVL.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (rst low, async) values:
  - rd_valid = 0, rd_ch = 0, rd_data = 0, count = 0, overflow = 0, underflow = 0.
  - write and read pointers = 0.
  - Storage contents are not reset.
- Derived flags are combinational from the registered count:
  - After reset: empty = 1, full = 0, almost_empty = 1, almost_full = (AFULL_LVL == 0).
- Write acceptance:
  - wr_acc = wr_en & !full, evaluated on pre-edge state.
  - The entry {wr_ch, wr_data} is written at wr_ptr; wr_ptr increments modulo DEPTH.
- Read acceptance:
  - rd_acc = rd_en & !empty, evaluated on pre-edge state.
  - The entry at rd_ptr is registered onto rd_ch/rd_data at that edge, so rd_valid = 1 the following cycle (latency 1). rd_ptr increments modulo DEPTH.
  - rd_data/rd_ch hold their last value when rd_valid = 0.
- Count update:
  - +1 if only wr_acc; -1 if only rd_acc; unchanged if both or neither.
- Simultaneous read and write:
  - When full, the write is rejected even if a read is accepted in the same cycle; overflow sets and count becomes DEPTH-1.
  - When empty, the read is rejected even if a write is accepted in the same cycle; underflow sets and count becomes 1.
  - When neither full nor empty, both are accepted and the read returns the older entry.
- Pointers are $clog2(DEPTH) bits and wrap naturally; ordering across the wrap is preserved.
- overflow and underflow are sticky; only rst or flush clears them.
- flush (synchronous, highest priority after reset):
  - Sets pointers, count, overflow and underflow to 0; rd_valid = 0 next cycle.
  - wr_en and rd_en in the same cycle are ignored.
- Reset mid-operation: all state returns to reset values immediately; no partial entries are ever reported.
- Storage is read-before-write within a cycle: a same-address read and write cannot occur when count >= 1, so no bypass is required.

Decomposition:
- Package adc_fifo_pkg holds:
  - default constants (ADC_DATA_WIDTH = 16, ADC_NUM_CH = 8);
  - function ch_w(n);
  - a packed struct adc_entry_t {ch, data} used for storage words.
- Sub-module adc_fifo_ram: simple dual-port synchronous RAM, DEPTH x (CH_W+DATA_WIDTH), registered read, no reset, so it infers block RAM.
- Control (pointers, count, flags) stays in adc_sample_fifo.

Test Plan (bench uses DEPTH=8, NUM_CH=8, AFULL_LVL=6, AEMPTY_LVL=1):
- Reset then write ch0..ch7 with data 0x1000+i, then read 8 → rd_valid pulses 8 times; rd_ch = 0..7 and rd_data = 0x1000..0x1007 in order; empty = 1 at the end; overflow = underflow = 0.
- Fill to 8, then assert wr_en with 0xBEEF → full = 1, count stays 8, overflow = 1; a subsequent read returns the first entry, not 0xBEEF.
- Hold count at 4, then wr_en and rd_en together for 20 cycles → count stays 4, pointers wrap at least twice, and read data matches the write order exactly.
- Empty, then rd_en and wr_en together with 0x00AA → read rejected, underflow = 1, count = 1; the next read returns 0x00AA with rd_valid = 1 exactly one cycle later.
- Threshold sweep 0→8→0 → almost_empty = 1 only at counts 0..1; almost_full = 1 only at counts 6..8.
- With count = 5 and overflow = 1: pulse flush → count 0, empty 1, overflow 0. Then, with count = 3, drive rst low asynchronously mid-cycle → all outputs at reset values before the next clock edge.
